// File: rtl/snd_pkg.sv
// Shared types and constants for the DMA sound sequencer.
// Sequencer states and the per-fetch address step (one 16-bit word = 2 bytes).
package snd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT,
    DRAIN,
    ABORT
  } state_t;

  localparam int SND_AW   = 22;
  localparam int WORD_INC = 2;

endpackage

// File: rtl/snd_fifo.sv
// Small synchronous sample FIFO between the DMA fetch path and the audio shifter.
// Pops on empty are ignored; flush empties it in one cycle and wins over push/pop.
module snd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [15:0]              din,
  output logic [15:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // The head reads as zero when nothing is buffered so the shifter never sees stale data.
  assign head    = empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snd_dma_seq.sv
// DMA sound frame sequencer: walks the frame address range one word per granted slot,
// buffers fetched words for the shifter, and handles repeat/stop at frame end.
module snd_dma_seq
  import snd_pkg::*;
#(
  parameter int AW    = SND_AW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sndon,
  input  logic          sfrep,
  input  logic [AW-1:0] frame_start,
  input  logic [AW-1:0] frame_end,
  input  logic          slot,
  input  logic          fetch_ack,
  input  logic [15:0]   fetch_data,
  input  logic          sample_pop,
  output logic          dma_req,
  output logic [AW-1:0] dma_addr,
  output logic [15:0]   sample,
  output logic          sample_valid,
  output logic [AW-1:0] snd,
  output logic          active,
  output logic          sint,
  output logic          stoff,
  output logic          underrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [AW-1:0] end_l;
  logic [AW-1:0] snd_next;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_flush;

  assign snd_next     = snd + AW'(WORD_INC);
  assign sample_valid = !fifo_empty;
  assign fifo_push    = (state == WAIT) && sndon && fetch_ack;
  // Any path back to IDLE other than a natural drain throws away buffered samples.
  assign fifo_flush   = (((state == LOAD) || (state == RUN) || (state == DRAIN)) && !sndon)
                      || ((state == WAIT) && !sndon && fetch_ack)
                      || ((state == ABORT) && fetch_ack);

  snd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (sample_pop),
    .flush (fifo_flush),
    .din   (fetch_data),
    .head  (sample),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      snd      <= '0;
      end_l    <= '0;
      dma_req  <= 1'b0;
      dma_addr <= '0;
      active   <= 1'b0;
      sint     <= 1'b0;
      stoff    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sint  <= 1'b0;
      stoff <= 1'b0;
      if (sample_pop && fifo_empty) underrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sndon) begin
            state  <= LOAD;
            active <= 1'b1;
          end
        end
        LOAD: begin
          if (!sndon) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            snd      <= frame_start;
            end_l    <= frame_end;
            underrun <= 1'b0;
            if (frame_start >= frame_end) begin
              sint   <= 1'b1;
              stoff  <= 1'b1;
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!sndon) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (slot && (fifo_count < CW'(DEPTH))) begin
            dma_req  <= 1'b1;
            dma_addr <= snd;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A fetch in flight must complete on the bus even if playback is switched off.
          if (!sndon) begin
            if (fetch_ack) begin
              dma_req <= 1'b0;
              state   <= IDLE;
              active  <= 1'b0;
            end else begin
              state <= ABORT;
            end
          end else if (fetch_ack) begin
            dma_req <= 1'b0;
            if (snd_next == end_l) begin
              sint <= 1'b1;
              if (sfrep) begin
                snd   <= frame_start;
                end_l <= frame_end;
                state <= RUN;
              end else begin
                stoff <= 1'b1;
                snd   <= snd_next;
                state <= DRAIN;
              end
            end else begin
              snd   <= snd_next;
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (!sndon || fifo_empty) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        ABORT: begin
          if (fetch_ack) begin
            dma_req <= 1'b0;
            state   <= IDLE;
            active  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snd_dma_seq.sv
// Scoreboard bench for snd_dma_seq: expected fetch addresses and sample words are queued
// by the stimulus/responder side and popped by a monitor on each request and each pop.
module tb_snd_dma_seq;

  localparam int AW = 22;

  logic          clk;
  logic          reset;
  logic          sndon;
  logic          sfrep;
  logic [AW-1:0] frame_start;
  logic [AW-1:0] frame_end;
  logic          slot;
  logic          fetch_ack;
  logic [15:0]   fetch_data;
  logic          sample_pop;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [15:0]   sample;
  logic          sample_valid;
  logic [AW-1:0] snd;
  logic          active;
  logic          sint;
  logic          stoff;
  logic          underrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] exp_addr[$];
  logic [15:0]   exp_data[$];

  int          ack_delay  = 1;
  bit          discard    = 0;
  logic [15:0] next_data  = 16'h1000;
  bit          pop_en     = 0;
  bit          pop_force  = 0;
  bit          pop_on_ack = 0;
  int          req_cnt    = 0;
  int          sint_cnt   = 0;
  int          stoff_cnt  = 0;

  snd_dma_seq #(.AW(AW), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sndon        (sndon),
    .sfrep        (sfrep),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .slot         (slot),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .sample_pop   (sample_pop),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .snd          (snd),
    .active       (active),
    .sint         (sint),
    .stoff        (stoff),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit on, input bit rep, input logic [AW-1:0] s,
                               input logic [AW-1:0] e, input bit sl);
    sndon       = on;
    sfrep       = rep;
    frame_start = s;
    frame_end   = e;
    slot        = sl;
  endtask

  // Memory model: acks after ack_delay cycles, data from a running counter.
  initial begin
    int wc;
    wc         = 0;
    fetch_ack  = 1'b0;
    fetch_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        fetch_ack = 1'b0;
        wc        = 0;
      end else if (fetch_ack) begin
        fetch_ack = 1'b0;
      end else if (dma_req) begin
        if (wc >= ack_delay - 1) begin
          fetch_ack  = 1'b1;
          fetch_data = next_data;
          if (!discard) exp_data.push_back(next_data);
          next_data  = next_data + 16'h0001;
          wc         = 0;
        end else begin
          wc++;
        end
      end
    end
  end

  // Shifter model.
  initial begin
    sample_pop = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sample_pop = pop_force || (pop_en && sample_valid) || (pop_on_ack && fetch_ack && sample_valid);
    end
  end

  // Monitor: compares every new request and every consumed sample against the queues.
  initial begin
    bit prev_req;
    bit prev_sint;
    bit prev_stoff;
    prev_req   = 1'b0;
    prev_sint  = 1'b0;
    prev_stoff = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dma_req && !prev_req) begin
          req_cnt++;
          if (exp_addr.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_req: got addr 0x%0h, expected no request", dma_addr);
          end else begin
            checkOutput("dma_addr", dma_addr, exp_addr.pop_front());
          end
        end
        if (sample_pop && sample_valid) begin
          if (exp_data.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_sample: got 0x%0h, expected none", sample);
          end else begin
            checkOutput("sample", sample, exp_data.pop_front());
          end
        end
        if (sint) begin
          sint_cnt++;
          checkOutput("sint_width", prev_sint, 0);
        end
        if (stoff) begin
          stoff_cnt++;
          checkOutput("stoff_width", prev_stoff, 0);
        end
      end
      prev_req   = dma_req;
      prev_sint  = sint;
      prev_stoff = stoff;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_req;
    int base_sint;
    int base_stoff;
    int n;
    bit seen;
    logic [15:0] d0;

    reset = 1'b1;
    applyStimulus(0, 0, '0, '0, 0);
    repeat (3) step();
    checkOutput("rst_dma_req", dma_req, 0);
    checkOutput("rst_dma_addr", dma_addr, 0);
    checkOutput("rst_sample_valid", sample_valid, 0);
    checkOutput("rst_sample", sample, 0);
    checkOutput("rst_snd", snd, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_sint_stoff", {sint, stoff, underrun}, 0);
    reset = 1'b0;
    step();

    // Basic frame, FIFO fills and then drains.
    $display("[TB] basic frame");
    base_sint  = sint_cnt;
    base_stoff = stoff_cnt;
    base_req   = req_cnt;
    exp_addr.push_back(22'h000100);
    exp_addr.push_back(22'h000102);
    exp_addr.push_back(22'h000104);
    exp_addr.push_back(22'h000106);
    applyStimulus(1, 0, 22'h000100, 22'h000108, 1);
    step();
    checkOutput("t1_active_rise", active, 1);
    checkOutput("t1_req_cycle1", dma_req, 0);
    step();
    checkOutput("t1_req_cycle2", dma_req, 0);
    step();
    checkOutput("t1_req_latency", dma_req, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (stoff) begin
        seen = 1;
        break;
      end
    end
    checkOutput("t1_stoff_seen", seen, 1);
    checkOutput("t1_sint_with_stoff", sint, 1);
    checkOutput("t1_snd_end", snd, 22'h000108);
    checkOutput("t1_active_drain", active, 1);
    repeat (3) step();
    checkOutput("t1_no_req_drain", dma_req, 0);
    checkOutput("t1_req_count", req_cnt - base_req, 4);
    pop_en = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!active) begin
        seen = 1;
        break;
      end
    end
    sndon = 0;
    checkOutput("t1_active_fall", seen, 1);
    checkOutput("t1_fifo_empty", sample_valid, 0);
    pop_en = 0;
    step();
    checkOutput("t1_sint_count", sint_cnt - base_sint, 1);
    checkOutput("t1_stoff_count", stoff_cnt - base_stoff, 1);

    // Repeat mode for three frames.
    $display("[TB] repeat");
    base_sint  = sint_cnt;
    base_stoff = stoff_cnt;
    for (int f = 0; f < 3; f++) begin
      exp_addr.push_back(22'h000100);
      exp_addr.push_back(22'h000102);
      exp_addr.push_back(22'h000104);
      exp_addr.push_back(22'h000106);
    end
    pop_en = 1;
    applyStimulus(1, 1, 22'h000100, 22'h000108, 1);
    n = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (sint) n++;
      if (n == 3) break;
    end
    applyStimulus(0, 1, 22'h000100, 22'h000108, 0);
    checkOutput("t2_sint_seen", n, 3);
    checkOutput("t2_snd_reload", snd, 22'h000100);
    repeat (3) step();
    pop_en = 0;
    checkOutput("t2_sint_count", sint_cnt - base_sint, 3);
    checkOutput("t2_stoff_none", stoff_cnt - base_stoff, 0);
    checkOutput("t2_addr_left", exp_addr.size(), 0);
    checkOutput("t2_idle", active, 0);
    exp_data.delete();

    // Backpressure: no pops, FIFO fills, then exactly one more fetch per pop.
    $display("[TB] backpressure");
    base_req = req_cnt;
    d0 = next_data;
    for (int k = 0; k < 5; k++) exp_addr.push_back(22'h000300 + 22'(2 * k));
    applyStimulus(1, 0, 22'h000300, 22'h000340, 1);
    repeat (20) step();
    checkOutput("t3_req_full", req_cnt - base_req, 4);
    checkOutput("t3_req_low", dma_req, 0);
    checkOutput("t3_head", sample, d0);
    pop_force = 1;
    step();
    pop_force = 0;
    repeat (10) step();
    checkOutput("t3_req_after_pop", req_cnt - base_req, 5);
    checkOutput("t3_req_low2", dma_req, 0);
    sndon = 0;
    repeat (2) step();
    checkOutput("t3_flushed", sample_valid, 0);
    exp_data.delete();

    // Abort with a slow ack.
    $display("[TB] abort");
    base_sint = sint_cnt;
    discard   = 1;
    ack_delay = 5;
    exp_addr.push_back(22'h000400);
    applyStimulus(1, 0, 22'h000400, 22'h000410, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dma_req) begin
        seen = 1;
        break;
      end
    end
    sndon = 0;
    checkOutput("t4_req_seen", seen, 1);
    repeat (4) step();
    checkOutput("t4_req_held", dma_req, 1);
    step();
    checkOutput("t4_req_dropped", dma_req, 0);
    checkOutput("t4_idle", active, 0);
    checkOutput("t4_discarded", sample_valid, 0);
    checkOutput("t4_snd_kept", snd, 22'h000400);
    step();
    checkOutput("t4_no_sint", sint_cnt - base_sint, 0);
    discard   = 0;
    ack_delay = 1;

    // Empty frame.
    $display("[TB] empty frame");
    base_req = req_cnt;
    applyStimulus(1, 1, 22'h000200, 22'h000200, 1);
    step();
    step();
    applyStimulus(0, 1, 22'h000200, 22'h000200, 1);
    checkOutput("t5_sint_stoff", {sint, stoff}, 2'b11);
    checkOutput("t5_idle", active, 0);
    checkOutput("t5_snd", snd, 22'h000200);
    step();
    checkOutput("t5_pulse_end", {sint, stoff}, 2'b00);
    checkOutput("t5_no_req", req_cnt - base_req, 0);

    // Underrun, sticky until LOAD.
    $display("[TB] underrun and simultaneity");
    applyStimulus(0, 0, 22'h000500, 22'h000502, 0);
    pop_force = 1;
    step();
    pop_force = 0;
    step();
    checkOutput("t6_underrun_set", underrun, 1);
    sndon = 1;
    step();
    checkOutput("t6_underrun_sticky", underrun, 1);
    step();
    sndon = 0;
    checkOutput("t6_underrun_clear", underrun, 0);
    repeat (2) step();

    // Push and pop on the same edge keep the occupancy at one word.
    for (int k = 0; k < 6; k++) exp_addr.push_back(22'h000600 + 22'(2 * k));
    pop_on_ack = 1;
    applyStimulus(1, 0, 22'h000600, 22'h00060C, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (stoff) begin
        seen = 1;
        break;
      end
    end
    pop_on_ack = 0;
    checkOutput("t6_stoff_seen", seen, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!sample_valid) break;
      pop_force = 1;
      step();
      pop_force = 0;
      n++;
    end
    sndon = 0;
    checkOutput("t6_occupancy", n, 1);
    repeat (2) step();
    checkOutput("t6_idle", active, 0);

    checkOutput("end_addr_queue", exp_addr.size(), 0);
    checkOutput("end_data_queue", exp_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snd_dma_seq.md
Name: snd_dma_seq

Overview:
Sequences STE-style DMA sound frame playback. Loads the frame start/end addresses into the sound address counter and schedules one word fetch per granted DMA slot into a small sample FIFO. Handles end-of-frame repeat or stop and raises the frame interrupt pulse. Sits between the sound control registers, the MCU DMA slot logic and the audio shifter.

Parameters:
AW, 22, sound address width; addresses are byte addresses, bit 0 always 0.
DEPTH, 4, sample FIFO depth in 16-bit words; power of 2, at least 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sndon  in  1  DMA sound enable (level)
sfrep  in  1  repeat mode; sampled at frame end
frame_start  in  AW  frame start address
frame_end  in  AW  frame end address, exclusive
slot  in  1  DMA slot available this cycle (strobe)
fetch_ack  in  1  fetch done; fetch_data valid
fetch_data  in  16  fetched word
sample_pop  in  1  shifter consumes FIFO head
dma_req  out  1  fetch request, held until fetch_ack
dma_addr  out  AW  fetch address
sample  out  16  FIFO head word
sample_valid  out  1  FIFO not empty
snd  out  AW  current address counter (register readback)
active  out  1  sequencer busy
sint  out  1  end-of-frame interrupt, 1-cycle pulse
stoff  out  1  playback stopped by end of frame, 1-cycle pulse
underrun  out  1  sticky: pop seen with FIFO empty

Behaviour:
- Reset: state IDLE; snd=0; end_l=0; dma_req=0; dma_addr=0; FIFO empty (sample_valid=0, sample=0); active=0; sint=0; stoff=0; underrun=0.
- States: IDLE, LOAD, RUN, WAIT, DRAIN, ABORT.
- IDLE, sndon=1: go to LOAD; active=1 from the next cycle.
- LOAD:
  - snd<=frame_start; end_l<=frame_end; underrun<=0.
  - If frame_start>=frame_end (empty frame): sint and stoff pulse, go to IDLE, regardless of sfrep.
  - Otherwise go to RUN.
- RUN, slot=1 and FIFO count<DEPTH: dma_req<=1, dma_addr<=snd, go to WAIT. So dma_req rises one cycle after the slot is sampled. Earliest dma_req is 2 cycles after sndon is seen.
- RUN, slot=1 and FIFO full: no request; the slot is lost.
- WAIT: dma_req stays 1 until fetch_ack. On the ack edge:
  - dma_req<=0; fetch_data is pushed; snd<=snd+2 (wraps modulo 2^AW).
  - If snd+2==end_l, sint pulses, then:
    - sfrep=1: snd<=frame_start, end_l<=frame_end (fresh values), go to RUN.
    - sfrep=0: stoff pulses, go to DRAIN.
  - Otherwise go to RUN.
- DRAIN: no fetches. When the FIFO is empty, go to IDLE and active<=0. sndon=1 in DRAIN has no effect until IDLE is reached.
- sndon=0 in LOAD, RUN or DRAIN: next state IDLE; FIFO flushed; active=0; no sint.
- sndon=0 in WAIT: go to ABORT. ABORT holds dma_req until fetch_ack, discards the data, leaves snd unchanged, then goes to IDLE with the FIFO flushed.
- FIFO rules:
  - Push and pop in the same cycle: count unchanged; the head advances.
  - Pop with the FIFO empty: ignored; underrun<=1, sticky until reset or LOAD.
  - A push when full cannot occur; the RUN guard prevents it.
- sint and stoff are registered and never asserted for 2 consecutive cycles.
- Reset has priority over all other inputs; reset mid-fetch drops dma_req immediately.

Decomposition:
- Shared package snd_pkg: state enum (IDLE..ABORT), AW default, word increment constant 2.
- One sub-module: snd_fifo (DEPTH×16 synchronous FIFO with push/pop/flush, count, empty/full).

Test Plan:
- Basic frame: start=0x000100, end=0x000108, sfrep=0, slot always 1, ack 1 cycle after req → 4 fetches at 0x100/0x102/0x104/0x106; sint and stoff pulse on the 4th ack; DRAIN to IDLE after 4 pops; active falls.
- Repeat: same frame, sfrep=1, 3 frames → addresses repeat from 0x100; exactly 3 sint pulses; stoff never asserts.
- Backpressure: no pops, DEPTH=4 → exactly 4 fetches, then dma_req stays 0 despite slot=1. One pop → exactly one more fetch.
- Abort: sndon=0 while dma_req=1 with the ack delayed 5 cycles → dma_req held until the ack; data discarded; sample_valid=0; IDLE; no sint.
- Empty frame: start=end=0x200 → no dma_req; one sint and one stoff pulse; IDLE after LOAD.
- Underrun and simultaneity: pop with the FIFO empty → underrun=1, cleared on the next LOAD. Push and pop in the same cycle → count unchanged; order preserved.
